// File: rtl/nios_onchip_ram_dp_if.sv
// rtl/nios_onchip_ram_dp_if.sv - Avalon-MM slave port bundle for the dual-port on-chip RAM
interface nios_onchip_ram_dp_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12
);
    logic [ADDR_WIDTH-1:0]   address;
    logic                    chipselect;
    logic                    read;
    logic                    write;
    logic [DATA_WIDTH/8-1:0] byteenable;
    logic [DATA_WIDTH-1:0]   writedata;
    logic [DATA_WIDTH-1:0]   readdata;
    logic                    readdatavalid;
    logic                    waitrequest;

    modport master (
        output address, chipselect, read, write, byteenable, writedata,
        input  readdata, readdatavalid, waitrequest
    );

    modport slave (
        input  address, chipselect, read, write, byteenable, writedata,
        output readdata, readdatavalid, waitrequest
    );
endinterface

// File: rtl/nios_onchip_ram_dp.sv
// rtl/nios_onchip_ram_dp.sv - true dual-port on-chip RAM with byte enables, read pipeline and clear engine
module nios_onchip_ram_dp #(
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    ADDR_WIDTH     = 12,
    parameter int                    READ_LATENCY   = 1,
    parameter int                    CLEAR_ON_RESET = 1,
    parameter logic [DATA_WIDTH-1:0] FILL_VALUE     = '0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clken,
    input  logic                      reset_req,
    nios_onchip_ram_dp_if.slave       s1,
    nios_onchip_ram_dp_if.slave       s2,
    output logic                      init_busy
);
    localparam int LANES = DATA_WIDTH / 8;
    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic {ST_CLEAR, ST_RUN} state_t;

    state_t                  state_q;
    logic [ADDR_WIDTH-1:0]   clr_cnt_q;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic [ADDR_WIDTH-1:0]   addr  [2];
    logic [LANES-1:0]        be    [2];
    logic [DATA_WIDTH-1:0]   wdata [2];
    logic [1:0]              cs, rd, wr;
    logic [1:0]              wait_d, acc_rd, acc_wr;
    logic                    en, clearing, collide, clr_we;

    logic [1:0]              v0_q, v1_q, rdv_q;
    logic [DATA_WIDTH-1:0]   rdata0_q   [2];
    logic [DATA_WIDTH-1:0]   rdata1_q   [2];
    logic [DATA_WIDTH-1:0]   readdata_q [2];

    assign addr[0]  = s1.address;
    assign addr[1]  = s2.address;
    assign be[0]    = s1.byteenable;
    assign be[1]    = s2.byteenable;
    assign wdata[0] = s1.writedata;
    assign wdata[1] = s2.writedata;
    assign cs       = {s2.chipselect, s1.chipselect};
    assign rd       = {s2.read, s1.read};
    assign wr       = {s2.write, s1.write};

    assign en       = clken & ~reset_req;
    assign clearing = (state_q == ST_CLEAR);
    assign clr_we   = en & clearing;

    // s1 always wins a same-address write race; s2 simply retries next cycle.
    assign collide   = cs[0] & wr[0] & cs[1] & wr[1] & (addr[0] == addr[1]);
    assign wait_d[0] = ~en | clearing;
    assign wait_d[1] = ~en | clearing | collide;

    assign acc_rd = cs & rd & ~wait_d;
    assign acc_wr = cs & wr & ~wait_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
            clr_cnt_q <= '0;
        end else if (en && state_q == ST_CLEAR) begin
            clr_cnt_q <= clr_cnt_q + 1'b1;
            if (clr_cnt_q == {ADDR_WIDTH{1'b1}}) begin
                state_q <= ST_RUN;
            end
        end
    end

    // Array and first read stage carry no reset so they map onto block RAM.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_cnt_q] <= FILL_VALUE;
        end
        for (int p = 0; p < 2; p++) begin
            for (int b = 0; b < LANES; b++) begin
                if (acc_wr[p] && be[p][b]) begin
                    mem[addr[p]][8*b +: 8] <= wdata[p][8*b +: 8];
                end
            end
            if (acc_rd[p]) begin
                rdata0_q[p] <= mem[addr[p]];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v0_q  <= '0;
            v1_q  <= '0;
            rdv_q <= '0;
            for (int p = 0; p < 2; p++) begin
                rdata1_q[p]   <= '0;
                readdata_q[p] <= '0;
            end
        end else if (en) begin
            v0_q <= acc_rd;
            v1_q <= v0_q;
            for (int p = 0; p < 2; p++) begin
                if (v0_q[p]) begin
                    rdata1_q[p] <= rdata0_q[p];
                end
            end
            if (READ_LATENCY == 2) begin
                rdv_q <= v1_q;
                for (int p = 0; p < 2; p++) begin
                    if (v1_q[p]) begin
                        readdata_q[p] <= rdata1_q[p];
                    end
                end
            end else begin
                rdv_q <= v0_q;
                for (int p = 0; p < 2; p++) begin
                    if (v0_q[p]) begin
                        readdata_q[p] <= rdata0_q[p];
                    end
                end
            end
        end
    end

    // Valids stay parked in the pipeline while frozen and are only shown once enabled.
    assign s1.readdata      = readdata_q[0];
    assign s1.readdatavalid = rdv_q[0] & en;
    assign s1.waitrequest   = wait_d[0];
    assign s2.readdata      = readdata_q[1];
    assign s2.readdatavalid = rdv_q[1] & en;
    assign s2.waitrequest   = wait_d[1];

    assign init_busy = clearing;
endmodule

// File: doc/nios_onchip_ram_dp.md
# nios_onchip_ram_dp

Parametrised true-dual-port on-chip RAM with two Avalon-MM slave ports (s1, s2), replacing the fixed 32-bit × 4096 single-port Nios memory in the CRC subsystem. It adds a selectable pipelined read latency with `readdatavalid`, per-byte write enables on both ports, and cross-port write-collision stalling. It also has an optional hardware clear engine that fills the array after reset. The CPU data master connects to s1; the CRC engine or DMA connects to s2.

## Interface
- `DATA_WIDTH`, 32: word width; multiple of 8; byte lanes = DATA_WIDTH/8.
- `ADDR_WIDTH`, 12: word address width; depth = 2^ADDR_WIDTH.
- `READ_LATENCY`, 1: 1 or 2 cycles from read acceptance to `readdatavalid`.
- `CLEAR_ON_RESET`, 1: 1 = fill the array with `FILL_VALUE` after reset; 0 = no clear, contents undefined.
- `FILL_VALUE`, 0: DATA_WIDTH-bit word written by the clear engine.
- `clk`  in  1  sole clock.
- `reset`  in  1  asynchronous, active-high reset.
- `clken`  in  1  global clock enable; 0 freezes the block.
- `reset_req`  in  1  1 freezes the block, same as `clken`=0.
- `sN_address`  in  ADDR_WIDTH  word address (N = 1, 2; identical port set per slave).
- `sN_chipselect`, `sN_read`, `sN_write`  in  1 each  Avalon controls; read and write never both high.
- `sN_byteenable`  in  DATA_WIDTH/8  write lane mask.
- `sN_writedata`  in  DATA_WIDTH  write data.
- `sN_readdata`  out  DATA_WIDTH  read data; meaningful only while `sN_readdatavalid`=1.
- `sN_readdatavalid`  out  1  one-cycle pulse per accepted read.
- `sN_waitrequest`  out  1  1 = request not accepted this cycle.
- `init_busy`  out  1  clear engine active.

## Operation
- **Freeze:** `en` = `clken` & ~`reset_req`. While `en`=0:
  - both `waitrequest`=1;
  - the read pipeline and clear counter hold;
  - `readdatavalid` outputs are forced to 0;
  - pending valids emerge once `en` returns to 1.
- **Acceptance:** a request on port N is accepted on a rising edge when `sN_chipselect`&(`sN_read`|`sN_write`)&~`sN_waitrequest`.
- **Writes:** only lanes with `byteenable`=1 are updated. A write with `byteenable`=0 is accepted and has no effect.
- **Reads:** return the full word and ignore `byteenable`.
- **Clear engine (CLEAR_ON_RESET=1):**
  - States: CLEAR and RUN.
  - Reset enters CLEAR with counter = 0.
  - In CLEAR, one word (counter) is written with `FILL_VALUE` per enabled cycle. Both `waitrequest`=1 and `init_busy`=1.
  - After writing word 2^ADDR_WIDTH−1, go to RUN.
  - Reset asserted mid-clear restarts CLEAR from word 0.
  - With CLEAR_ON_RESET=0, reset enters RUN directly.
- **Collision:** s1 write and s2 write to the same address in the same cycle → s2 `waitrequest`=1 for that cycle and s1 completes. s2 completes on the next cycle if it is still presented. s1 never stalls because of s2.
- **Cross-port read/write, same address, same cycle:** the reader gets the old data.
- **Same port, consecutive cycles:** a read following a write to the same address returns the new data.

## Timing
- **Reset values:**
  - `sN_readdata`=0, `sN_readdatavalid`=0;
  - `init_busy`=CLEAR_ON_RESET;
  - `sN_waitrequest`=CLEAR_ON_RESET, OR'd with the freeze condition.
- **Clear duration:** 2^ADDR_WIDTH enabled cycles. `waitrequest` and `init_busy` fall on the edge that writes the last word.
- **Read latency:**
  - READ_LATENCY=1: a read accepted at edge k drives `readdatavalid`=1 and `readdata` during the cycle after edge k+1's output update, i.e. registered one edge later. Back-to-back reads give one valid per cycle.
  - READ_LATENCY=2: adds one output register stage; still fully pipelined.
- **waitrequest:** combinational from the current inputs (collision compare) and state. It has no other wait states, so throughput is one access per port per cycle.
- **readdata between valids:** holds its last value; 0 after reset.

## Test plan
1. CLEAR_ON_RESET=1, ADDR_WIDTH=4, FILL_VALUE=0xA5A5A5A5: release reset → `init_busy` high for exactly 16 cycles. Then reading words 0 and 15 returns 0xA5A5A5A5 with `readdatavalid` 1 cycle after acceptance.
2. s1 writes 0x11223344 to address 5, then writes 0xDDCCBBAA with byteenable=0b0001. s2 reads address 5 → 0x112233AA.
3. Same-cycle writes to address 7: s1 writes 0x1, s2 writes 0x2. s2 `waitrequest` is 1 for one cycle, and s2's write lands next cycle. The final read returns 0x2.
4. READ_LATENCY=2: s2 issues reads to addresses 0, 1, 2 on consecutive cycles. Three consecutive `readdatavalid` pulses start 2 cycles after the first acceptance, with data in order.
5. `reset_req`=1 for 3 cycles while a READ_LATENCY=2 read is in flight. `readdatavalid` stays 0 and both `waitrequest`=1. The valid appears after `reset_req` falls, with the correct data.
6. Assert `reset` at clear word 9 → outputs return to their reset values immediately. The clear restarts at word 0 and takes the full 2^ADDR_WIDTH cycles.
